uart_rx_ctrl: RTL and testbench

// - UART receive sequencer: detects the start bit on rxd and aligns the RX baud counter via sample_clk_clr.
// - Majority-votes each bit from voting_edge/sample_edge pulses supplied by transfer_clock_gen.
// - Assembles 5-8 bit frames, checks parity/stop, flags breaks; hands bytes to the RX FIFO as single-cycle pulses.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 39 +++
 rtl/uart_rx_ctrl.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, word-length codes and decode helper.
// Pure definitions; no logic or latency.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Reset-valued flop and the rxd synchronizer chain built from it.
// SYNC_STAGES pclk latency; no backpressure, presets to idle-line 1.
module dff #(
    parameter int         WIDTH       = 1,
    parameter logic [0:0] RESET_VALUE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= {WIDTH{RESET_VALUE}};
        else        q <= d;
    end
endmodule

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES:0] chain;

    assign chain[0] = d;
    assign q        = chain[SYNC_STAGES];

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
        dff #(.WIDTH(1), .RESET_VALUE(1'b1)) u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, 3-vote bit decision, 5-8 bit framing, parity/stop/break checks.
// rx_valid is a 1-cycle pulse one pclk after the stop-bit sample_edge; no backpressure on rx_valid.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              rx_en,
    input  logic              rxd,
    input  logic [1:0]        lcr_wls,
    input  logic              lcr_pen,
    input  logic              lcr_eps,
    input  logic              lcr_sp,
    input  logic              voting_edge,
    input  logic              sample_edge,
    output logic              sample_clk_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              framing_err,
    output logic              break_int,
    output logic              rx_busy
);

    rx_state_e         state;
    logic              rxd_s;
    logic              rxd_d;
    logic              fall;
    logic              sample_d;
    logic [1:0]        vote_cnt;
    logic [1:0]        ones_cnt;
    logic              vote_add;
    logic              vote_clr;
    logic [2:0]        vote_eff;
    logic [2:0]        ones_eff;
    logic              bit_val;
    logic [3:0]        bit_cnt;
    logic [3:0]        last_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_err_q;
    logic              par_bit_q;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rxd_d    <= 1'b1;
            sample_d <= 1'b0;
        end else begin
            rxd_d    <= rxd_s;
            sample_d <= sample_edge;
        end
    end

    assign fall           = rxd_d & ~rxd_s;
    assign sample_clk_clr = (state == ST_IDLE) & fall & rx_en;
    assign rx_busy        = (state != ST_IDLE);
    assign last_idx       = wls_to_bits(lcr_wls) - 4'd1;

    // A vote landing on the sample_edge cycle is folded in combinationally so it counts toward this bit.
    assign vote_add = voting_edge & (vote_cnt != 2'd3);
    assign vote_eff = {1'b0, vote_cnt} + {2'b00, vote_add};
    assign ones_eff = {1'b0, ones_cnt} + {2'b00, vote_add & rxd_s};
    assign bit_val  = (vote_eff == 3'd0) ? rxd_s : ({ones_eff, 1'b0} > {1'b0, vote_eff});
    assign vote_clr = sample_d | sample_clk_clr | ~rx_en;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            vote_cnt <= 2'd0;
            ones_cnt <= 2'd0;
        end else if (vote_clr) begin
            // A vote on the clearing cycle opens the new bit rather than being lost.
            vote_cnt <= {1'b0, voting_edge & rx_en};
            ones_cnt <= {1'b0, voting_edge & rx_en & rxd_s};
        end else begin
            vote_cnt <= vote_eff[1:0];
            ones_cnt <= ones_eff[1:0];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shreg       <= '0;
            par_err_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_int   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!rx_en) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (fall) state <= ST_START;
                    end
                    ST_START: begin
                        if (sample_edge) begin
                            if (!bit_val) begin
                                state     <= ST_DATA;
                                bit_cnt   <= 4'd0;
                                shreg     <= '0;
                                par_err_q <= 1'b0;
                                par_bit_q <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sample_edge) begin
                            for (int i = 0; i < DATA_W; i++) begin
                                if (bit_cnt == i[3:0]) shreg[i] <= bit_val;
                            end
                            // A mid-frame wls change just lets bit_cnt wrap around until it matches again.
                            if (bit_cnt == last_idx) state <= lcr_pen ? ST_PARITY : ST_STOP;
                            else                     bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (sample_edge) begin
                            par_bit_q <= bit_val;
                            if (lcr_sp) par_err_q <= (bit_val != ~lcr_eps);
                            else        par_err_q <= ((^shreg ^ bit_val) != ~lcr_eps);
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (sample_edge) begin
                            rx_valid    <= 1'b1;
                            rx_data     <= shreg;
                            parity_err  <= par_err_q;
                            framing_err <= ~bit_val;
                            break_int   <= ~bit_val & (shreg == '0) & ~par_bit_q;
                            state       <= bit_val ? ST_IDLE : ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rxd_s) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed frames into uart_rx_ctrl with a 16-clock bit period; a queue-based monitor checks every rx_valid.
module tb_uart_rx_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       rx_en;
    logic       rxd;
    logic [1:0] lcr_wls;
    logic       lcr_pen;
    logic       lcr_eps;
    logic       lcr_sp;
    logic       voting_edge;
    logic       sample_edge;
    logic       sample_clk_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_int;
    logic       rx_busy;

    logic [3:0] cnt = 4'd0;
    exp_t       exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;

    uart_rx_ctrl #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .rx_en          (rx_en),
        .rxd            (rxd),
        .lcr_wls        (lcr_wls),
        .lcr_pen        (lcr_pen),
        .lcr_eps        (lcr_eps),
        .lcr_sp         (lcr_sp),
        .voting_edge    (voting_edge),
        .sample_edge    (sample_edge),
        .sample_clk_clr (sample_clk_clr),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_err     (parity_err),
        .framing_err    (framing_err),
        .break_int      (break_int),
        .rx_busy        (rx_busy)
    );

    always #5 pclk = ~pclk;

    // Stand-in for the baud generator: votes at 6,7,8, decision at 8 (coincident with the last vote).
    always @(posedge pclk) begin
        if (sample_clk_clr) cnt <= 4'd0;
        else                cnt <= cnt + 4'd1;
    end
    assign voting_edge = (cnt == 4'd6) || (cnt == 4'd7) || (cnt == 4'd8);
    assign sample_edge = (cnt == 4'd8);

    always @(negedge pclk) begin
        if (presetn === 1'b1 && rx_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_rx_valid: got data=%02h pe=%b fe=%b bi=%b, required no rx_valid",
                         rx_data, parity_err, framing_err, break_int);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rx_data === e.data && parity_err === e.pe && framing_err === e.fe && break_int === e.bi)
                    n_pass++;
                else
                    $display("FAIL frame_%02h: got data=%02h pe=%b fe=%b bi=%b, required data=%02h pe=%b fe=%b bi=%b",
                             e.data, rx_data, parity_err, framing_err, break_int, e.data, e.pe, e.fe, e.bi);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.bi = bi;
        exp_q.push_back(e);
    endtask

    task automatic set_lcr(input logic [1:0] wls, input logic pen, input logic eps, input logic sp);
        lcr_wls = wls; lcr_pen = pen; lcr_eps = eps; lcr_sp = sp;
    endtask

    // abort: 0 none, 1 drop rx_en, 2 assert presetn -- both at data bit 3.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen, input logic pbit,
                              input int nstop, input logic stopv, input logic corrupt, input int abort);
        logic bits [0:12];
        int   n;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int j = 0; j < nbits; j++) begin bits[n] = d[j]; n++; end
        if (pen) begin bits[n] = pbit; n++; end
        for (int j = 0; j < nstop; j++) begin bits[n] = stopv; n++; end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge pclk);
                if (abort != 0 && i == 4 && k == 5) begin
                    rxd = 1'b1;
                    if (abort == 1) rx_en = 1'b0;
                    else            presetn = 1'b0;
                    return;
                end
                rxd = bits[i] ^ (corrupt && i >= 1 && i <= nbits && k == ((i % 2 == 1) ? 7 : 9));
            end
        end
    endtask

    initial begin
        presetn = 1'b0;
        rx_en   = 1'b0;
        rxd     = 1'b1;
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge pclk);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_framing_err", {31'd0, framing_err}, 32'd0);
        check("reset_break_int", {31'd0, break_int}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_sample_clk_clr", {31'd0, sample_clk_clr}, 32'd0);
        presetn = 1'b1;
        rx_en   = 1'b1;
        repeat (5) @(negedge pclk);

        // Back-to-back: 8N1, 7E1 with a wrong parity bit, 5O2, 6-bit stick parity with a wrong bit.
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0); expect_frame(8'hA5, 0, 0, 0);
        send_frame(8'hA5, 8, 0, 0, 1, 1, 0, 0);
        set_lcr(2'b10, 1'b1, 1'b1, 1'b0); expect_frame(8'h35, 1, 0, 0);
        send_frame(8'h35, 7, 1, 1, 1, 1, 0, 0);
        set_lcr(2'b00, 1'b1, 1'b0, 1'b0); expect_frame(8'h1F, 0, 0, 0);
        send_frame(8'h1F, 5, 1, 0, 2, 1, 0, 0);
        set_lcr(2'b01, 1'b1, 1'b0, 1'b1); expect_frame(8'h2A, 1, 0, 0);
        send_frame(8'h2A, 6, 1, 0, 1, 1, 0, 0);

        // Break: all zeros with stop low, line held low afterwards.
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0); expect_frame(8'h00, 0, 1, 1);
        send_frame(8'h00, 8, 0, 0, 1, 0, 0, 0);
        repeat (48) @(negedge pclk);
        check("wait_idle_busy_while_low", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        repeat (20) @(negedge pclk);
        check("wait_idle_released", {31'd0, rx_busy}, 32'd0);
        expect_frame(8'h5A, 0, 0, 0);
        send_frame(8'h5A, 8, 0, 0, 1, 1, 0, 0);

        // Start glitch: 2 pclk low.
        @(negedge pclk); rxd = 1'b0;
        @(negedge pclk);
        @(negedge pclk); rxd = 1'b1;
        repeat (4) @(negedge pclk);
        check("glitch_in_start", {31'd0, rx_busy}, 32'd1);
        repeat (30) @(negedge pclk);
        check("glitch_back_idle", {31'd0, rx_busy}, 32'd0);

        // One vote of every data bit corrupted, odd bits on the coincident vote/sample cycle.
        expect_frame(8'h3C, 0, 0, 0);
        send_frame(8'h3C, 8, 0, 0, 1, 1, 1, 0);
        repeat (8) @(negedge pclk);

        send_frame(8'h77, 8, 0, 0, 1, 1, 0, 1);
        @(negedge pclk);
        check("rx_en_drop_idle", {31'd0, rx_busy}, 32'd0);
        rx_en = 1'b1;
        repeat (40) @(negedge pclk);
        check("rx_en_drop_still_idle", {31'd0, rx_busy}, 32'd0);
        check("rx_en_drop_data_held", {24'd0, rx_data}, 32'h3C);

        send_frame(8'h55, 8, 0, 0, 1, 1, 0, 2);
        repeat (2) @(negedge pclk);
        check("midframe_reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midframe_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midframe_reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("midframe_reset_errs", {29'd0, parity_err, framing_err, break_int}, 32'd0);
        presetn = 1'b1;
        repeat (5) @(negedge pclk);
        expect_frame(8'h81, 0, 0, 0);
        send_frame(8'h81, 8, 0, 0, 1, 1, 0, 0);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge pclk);
        check("all_frames_delivered", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
